// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus of pc_fetch_ctrl. It bundles two links:
//   the instruction-memory request/ack link: imem_req, imem_addr, imem_ack, imem_rdata
//   the decode valid/ready link: instr_valid, instr, instr_pc, instr_ready
// The master modport is the fetch controller. The slave modport is the memory/decode side.
interface pc_fetch_ctrl_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned IW = 32
);
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [W-1:0]  instr_pc;
  logic          instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch sequencer.
// It owns the word-addressed PC and issues req/ack fetches to instruction memory.
// It buffers one instruction for decode behind a valid/ready handshake.
// It redirects the PC on br_valid and squashes any stale fetch.
// It stops fetching while halt is high.
// Ports:
//   clk        clock
//   clr_n      asynchronous active-low reset
//   bus        fetch bus, master side (imem req/ack plus decode valid/ready)
//   br_valid   redirect request
//   br_target  redirect target address
//   halt       level request to stop issuing fetches
//   halted     high while in the HALTED state
// All outputs come straight from flops.
module pc_fetch_ctrl #(
  parameter int unsigned   W        = 32,
  parameter int unsigned   IW       = 32,
  parameter logic [W-1:0]  RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   clr_n,
  pc_fetch_ctrl_if.master        bus,
  input  logic                   br_valid,
  input  logic [W-1:0]           br_target,
  input  logic                   halt,
  output logic                   halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    HOLD   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t        state_q, state_n;
  logic [W-1:0]  pc_q, pc_n;
  logic [W-1:0]  addr_q, addr_n;
  logic          req_q, req_n;
  logic          valid_q, valid_n;
  logic [IW-1:0] instr_q, instr_n;
  logic [W-1:0]  ipc_q, ipc_n;
  logic          halted_q, halted_n;

  logic          ack;
  logic          xfer;
  state_t        resume;

  assign ack    = bus.imem_ack;
  assign xfer   = valid_q & bus.instr_ready;
  // Where to go once the current fetch or transfer has completed.
  assign resume = halt ? HALTED : REQ;

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    valid_n = valid_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;

    unique case (state_q)
      IDLE: state_n = resume;

      REQ: begin
        if (br_valid) begin
          pc_n = br_target;
          // With an ack, the returning word is stale, so it is dropped and the target is fetched at once.
          // Without an ack, the outstanding request must first complete in DRAIN.
          state_n = ack ? REQ : DRAIN;
        end else if (ack) begin
          pc_n    = pc_q + W'(1);
          instr_n = bus.imem_rdata;
          ipc_n   = pc_q;
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end

      HOLD: begin
        // A transfer in the same cycle as a branch still completes on the decode side.
        if (br_valid) begin
          pc_n    = br_target;
          valid_n = 1'b0;
          state_n = resume;
        end else if (xfer) begin
          valid_n = 1'b0;
          state_n = resume;
        end
      end

      DRAIN: begin
        if (br_valid) begin
          pc_n = br_target;
        end
        // The squashed request ends on its ack. Leaving DRAIN then also prevents waiting for an ack that never comes.
        if (ack) begin
          state_n = resume;
        end
      end

      HALTED: begin
        if (br_valid) begin
          pc_n = br_target;
        end else if (!halt) begin
          state_n = REQ;
        end
      end

      default: state_n = IDLE;
    endcase

    req_n    = (state_n == REQ) || (state_n == DRAIN);
    halted_n = (state_n == HALTED);
    // A new request presents the current PC. DRAIN keeps the squashed address on the bus.
    addr_n   = (state_n == REQ) ? pc_n : addr_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      addr_q   <= addr_n;
      req_q    <= req_n;
      valid_q  <= valid_n;
      instr_q  <= instr_n;
      ipc_q    <= ipc_n;
      halted_q <= halted_n;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, streaming, stall, branch squash, halt and PC wrap.
module tb_pc_fetch_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 32;
  localparam logic [IW-1:0] SALT = 32'hC0DE_5000;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         br_valid = 1'b0;
  logic [W-1:0] br_target = '0;
  logic         halt = 1'b0;
  logic         halted;
  logic         ack_auto = 1'b0;
  logic         ack_force = 1'b0;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  logic seen_40 = 1'b0;

  pc_fetch_ctrl_if #(.W(W), .IW(IW)) bus ();

  // Memory model: the returned word identifies its address.
  assign bus.imem_ack   = (ack_auto & bus.imem_req) | ack_force;
  assign bus.imem_rdata = bus.imem_addr ^ SALT;

  pc_fetch_ctrl #(.W(W), .IW(IW), .RESET_PC('0)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .bus      (bus.master),
    .br_valid (br_valid),
    .br_target(br_target),
    .halt     (halt),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Count decode transfers. The inputs are stable around the negedge.
  always @(negedge clk) begin
    if (clr_n && bus.instr_valid && bus.instr_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      if (bus.instr_pc == 32'h40) seen_40 <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    repeat (2) step();

    // 1: reset state, release, then reset again mid-REQ
    chk_b("rst_req", bus.imem_req, 1'b0);
    chk_b("rst_valid", bus.instr_valid, 1'b0);
    chk_b("rst_halted", halted, 1'b0);
    chk_w("rst_addr", bus.imem_addr, 32'h0);
    chk_w("rst_instr", bus.instr, 32'h0);
    chk_w("rst_ipc", bus.instr_pc, 32'h0);
    clr_n = 1'b1;
    chk_b("idle_req", bus.imem_req, 1'b0);
    step();
    chk_b("first_req", bus.imem_req, 1'b1);
    chk_w("first_addr", bus.imem_addr, 32'h0);
    step();
    chk_b("wait_req", bus.imem_req, 1'b1);
    chk_w("wait_addr", bus.imem_addr, 32'h0);
    clr_n = 1'b0;
    #1;
    chk_b("midreq_rst_req", bus.imem_req, 1'b0);
    chk_b("midreq_rst_valid", bus.instr_valid, 1'b0);
    ack_force = 1'b1;
    step();
    chk_b("late_ack_req", bus.imem_req, 1'b0);
    chk_b("late_ack_valid", bus.instr_valid, 1'b0);
    clr_n = 1'b1;
    step();
    ack_force = 1'b0;
    chk_b("rel_req", bus.imem_req, 1'b1);
    chk_w("rel_addr", bus.imem_addr, 32'h0);
    chk_b("rel_valid", bus.instr_valid, 1'b0);

    // 2: zero-wait streaming of addresses 0..3
    ack_auto = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_b("strm_req", bus.imem_req, 1'b1);
      chk_w("strm_addr", bus.imem_addr, W'(i));
      step();
      chk_b("strm_valid", bus.instr_valid, 1'b1);
      chk_w("strm_ipc", bus.instr_pc, W'(i));
      chk_w("strm_instr", bus.instr, W'(i) ^ SALT);
      chk_b("strm_noreq", bus.imem_req, 1'b0);
      step();
    end
    chk_w("strm_xfers", W'(xfer_cnt), 32'd4);

    // 3: stall for 5 cycles on instruction 4
    bus.instr_ready = 1'b0;
    step();
    chk_w("stall_ipc0", bus.instr_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_b("stall_valid", bus.instr_valid, 1'b1);
      chk_w("stall_ipc", bus.instr_pc, 32'h4);
      chk_w("stall_instr", bus.instr, 32'hC0DE_5004);
      chk_b("stall_noreq", bus.imem_req, 1'b0);
    end
    bus.instr_ready = 1'b1;
    step();
    chk_b("unstall_req", bus.imem_req, 1'b1);
    chk_w("unstall_addr", bus.imem_addr, 32'h5);
    chk_b("unstall_valid", bus.instr_valid, 1'b0);
    chk_w("stall_xfers", W'(xfer_cnt), 32'd5);

    // 4: branch during a wait-stated fetch of address 5
    ack_auto = 1'b0;
    step();
    chk_w("ws_addr", bus.imem_addr, 32'h5);
    br_valid = 1'b1;
    br_target = 32'h40;
    step();
    br_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_b("drain_req", bus.imem_req, 1'b1);
      chk_w("drain_addr", bus.imem_addr, 32'h5);
      chk_b("drain_valid", bus.instr_valid, 1'b0);
      step();
    end
    chk_w("drain_addr_last", bus.imem_addr, 32'h5);
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    chk_b("post_drain_req", bus.imem_req, 1'b1);
    chk_w("post_drain_addr", bus.imem_addr, 32'h40);
    chk_b("post_drain_valid", bus.instr_valid, 1'b0);

    // 5b: branch in HOLD without ready squashes the instruction at 0x40
    bus.instr_ready = 1'b0;
    ack_auto = 1'b1;
    step();
    chk_w("hold40_ipc", bus.instr_pc, 32'h40);
    chk_w("hold40_instr", bus.instr, 32'hC0DE_5040);
    br_valid = 1'b1;
    br_target = 32'h80;
    step();
    br_valid = 1'b0;
    chk_b("squash_valid", bus.instr_valid, 1'b0);
    chk_w("squash_addr", bus.imem_addr, 32'h80);
    step();
    chk_w("hold80_ipc", bus.instr_pc, 32'h80);
    chk_w("squash_xfers", W'(xfer_cnt), 32'd5);
    chk_b("never_40", seen_40, 1'b0);

    // 5a: branch in HOLD with ready; 0x80 still transfers once
    br_valid = 1'b1;
    br_target = 32'h10;
    bus.instr_ready = 1'b1;
    step();
    br_valid = 1'b0;
    chk_w("br_xfer_cnt", W'(xfer_cnt), 32'd6);
    chk_b("br_xfer_valid", bus.instr_valid, 1'b0);
    chk_w("br_xfer_addr", bus.imem_addr, 32'h10);

    // 6: halt after the current transfer, redirect while halted, wrap past 2^W-1
    halt = 1'b1;
    step();
    chk_w("pre_halt_ipc", bus.instr_pc, 32'h10);
    chk_b("pre_halt_halted", halted, 1'b0);
    step();
    chk_b("halted", halted, 1'b1);
    chk_b("halted_noreq", bus.imem_req, 1'b0);
    chk_b("halted_valid", bus.instr_valid, 1'b0);
    chk_w("halt_xfers", W'(xfer_cnt), 32'd7);
    br_valid = 1'b1;
    br_target = 32'hFFFF_FFFF;
    step();
    br_valid = 1'b0;
    chk_b("halted_br_halted", halted, 1'b1);
    chk_b("halted_br_noreq", bus.imem_req, 1'b0);
    halt = 1'b0;
    step();
    chk_b("resume_halted", halted, 1'b0);
    chk_b("resume_req", bus.imem_req, 1'b1);
    chk_w("resume_addr", bus.imem_addr, 32'hFFFF_FFFF);
    step();
    chk_w("top_ipc", bus.instr_pc, 32'hFFFF_FFFF);
    chk_w("top_instr", bus.instr, 32'h3F21_AFFF);
    step();
    chk_b("wrap_req", bus.imem_req, 1'b1);
    chk_w("wrap_addr", bus.imem_addr, 32'h0);
    step();
    chk_w("wrap_ipc", bus.instr_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
